// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
// Optional feature macro: FIFO_DRAIN_TIMEOUT_EN (stall timeout in fifo_drain_ctrl).
package fifo_drain_pkg;

  // Widths shared with the 8-bit FIFO data path and its 5-bit pointers.
  localparam int unsigned FifoDataW = 8;
  localparam int unsigned FifoCntW  = 5;

  // Legal range of the FIFO read latency.
  localparam int unsigned RdLatencyMin = 1;
  localparam int unsigned RdLatencyMax = 3;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StIssue = 5'b00010,
    StWait  = 5'b00100,
    StHold  = 5'b01000,
    StDone  = 5'b10000
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream of the drain controller.
// master: the drain controller; slave: the FIFO/downstream side.
interface fifo_drain_ctrl_if
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = FifoDataW
);
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_underflow;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  fifo_data,
    input  fifo_underflow,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output fifo_data,
    output fifo_underflow,
    output m_ready
  );
endinterface

// File: rtl/drain_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Shared between the read-latency wait and the stall timeout.
module drain_wait_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [Width-1:0] count_q, count_d;

  // Next count: load wins over decrement; hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: strobes the FIFO one word at a time, waits
// RD_LATENCY cycles, then holds the word on a valid/ready stream until accepted.
// Optional feature macro: FIFO_DRAIN_TIMEOUT_EN (abandon a burst after TIMEOUT
// consecutive empty cycles in ISSUE and flag timed_out).
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W     = FifoDataW,
  parameter int unsigned CNT_W      = FifoCntW,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  fifo_drain_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_done,
  output logic             timed_out
);

  if ((RD_LATENCY < RdLatencyMin) || (RD_LATENCY > RdLatencyMax)) begin : g_bad_latency
    $error("fifo_drain_ctrl: RD_LATENCY out of range");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("fifo_drain_ctrl: TIMEOUT must be nonzero");
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int unsigned WaitW     = $clog2(max_u(TIMEOUT, RdLatencyMax) + 1);
  localparam int unsigned StallLoad = TIMEOUT;
`else
  localparam int unsigned WaitW     = $clog2(RdLatencyMax + 1);
  localparam int unsigned StallLoad = 0;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic [CNT_W-1:0]    words_done_q, words_done_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                abort_seen_q, abort_seen_d;

  logic                rd_en;
  logic                cnt_load;
  logic [WaitW-1:0]    cnt_load_val;
  logic                cnt_dec;
  logic                cnt_zero;
  logic                start_ok;
  logic                timeout_hit;
  logic                timeout_fire;

  drain_wait_counter #(
    .Width (WaitW)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign start_ok = (state_q == StIdle) && start && (burst_len != '0);

`ifdef FIFO_DRAIN_TIMEOUT_EN
  // In ISSUE the counter holds the remaining stall budget.
  assign timeout_hit = cnt_zero;
`else
  assign timeout_hit = 1'b0;
`endif
  assign timeout_fire = (state_q == StIssue) && !abort && timeout_hit;

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    words_done_d = words_done_q;
    remaining_d  = remaining_q;
    abort_seen_d = abort_seen_q;
    rd_en        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          remaining_d  = burst_len;
          words_done_d = '0;
          abort_seen_d = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = WaitW'(StallLoad);
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StDone;
        end else if (timeout_fire) begin
          state_d = StDone;
        end else if (!bus.fifo_underflow) begin
          rd_en        = 1'b1;
          abort_seen_d = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = WaitW'(RD_LATENCY - 1);
          state_d      = StWait;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWait: begin
        if (abort) begin
          abort_seen_d = 1'b1;
        end
        if (cnt_zero) begin
          m_data_d  = bus.fifo_data;
          m_valid_d = 1'b1;
          state_d   = StHold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHold: begin
        if (abort) begin
          abort_seen_d = 1'b1;
        end
        if (bus.m_ready) begin
          m_valid_d    = 1'b0;
          words_done_d = words_done_q + CNT_W'(1);
          remaining_d  = remaining_q - CNT_W'(1);
          if ((remaining_q == CNT_W'(1)) || abort_seen_q || abort) begin
            state_d = StDone;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = WaitW'(StallLoad);
            state_d      = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      words_done_q <= '0;
      remaining_q  <= '0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      words_done_q <= words_done_d;
      remaining_q  <= remaining_d;
      abort_seen_q <= abort_seen_d;
    end
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic timed_out_q;

  // Sticky timeout flag, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      timed_out_q <= 1'b0;
    end else if (start_ok) begin
      timed_out_q <= 1'b0;
    end else if (timeout_fire) begin
      timed_out_q <= 1'b1;
    end
  end
  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

  // Strobe is masked during reset so a mid-burst reset never issues a read.
  assign bus.fifo_rd_en = rd_en && !reset;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign words_done     = words_done_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl with a behavioural FIFO (RD_LATENCY=1).
module tb_fifo_drain_ctrl;
  localparam int unsigned DataW = 8;
  localparam int unsigned CntW  = 5;
  localparam int unsigned RdLat = 1;
`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 64;
`endif

  logic            clk;
  logic            reset;
  logic            start;
  logic [CntW-1:0] burst_len;
  logic            abort;
  logic            busy;
  logic            done;
  logic [CntW-1:0] words_done;
  logic            timed_out;

  fifo_drain_ctrl_if #(.DATA_W(DataW)) bus ();

  fifo_drain_ctrl #(
    .DATA_W     (DataW),
    .CNT_W      (CntW),
    .RD_LATENCY (RdLat),
    .TIMEOUT    (TbTimeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .timed_out  (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: one-cycle read latency.
  logic [DataW-1:0] mem [0:63];
  int               wp = 0;
  int               rp = 0;
  logic [DataW-1:0] rd_data = '0;
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_data <= mem[rp[5:0]];
      rp      <= rp + 1;
    end
  end
  assign bus.fifo_data      = rd_data;
  assign bus.fifo_underflow = (wp == rp);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DataW-1:0] exp_q [$];
  int               strobes     = 0;
  int               last_strobe = 0;
  logic             prev_valid  = 1'b0;
  logic             prev_ready  = 1'b0;
  logic [DataW-1:0] prev_data   = '0;

  // Monitor: protocol checks and scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fifo_rd_en) begin
        check("no_read_while_empty", {31'd0, bus.fifo_underflow}, 32'd0);
        check("single_outstanding", {31'd0, bus.m_valid}, 32'd0);
        strobes++;
        last_strobe = cyc;
      end
      if (bus.m_valid && !prev_valid) begin
        check("valid_latency", cyc - last_strobe, RdLat + 1);
      end
      if (bus.m_valid && prev_valid && !prev_ready) begin
        check("hold_stable", {24'd0, bus.m_data}, {24'd0, prev_data});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
        end else begin
          check("m_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_valid = bus.m_valid;
    prev_ready = bus.m_ready;
    prev_data  = bus.m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DataW-1:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  task automatic start_burst(input int len);
    start     = 1'b1;
    burst_len = CntW'(len);
    tick();
    start     = 1'b0;
    burst_len = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.m_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus.m_valid) check(name, 32'd0, 32'd1);
  endtask

  int s0;
  int cyc0;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    burst_len   = '0;
    abort       = 1'b0;
    bus.m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    check("rst_words_done", {27'd0, words_done}, 32'd0);
    check("rst_timed_out", {31'd0, timed_out}, 32'd0);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);

    // abort and zero-length start in IDLE do nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start_burst(0);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);

    // Burst of 3, ready always high.
    bus.m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    s0 = strobes;
    start_burst(3);
    wait_done("burst3_done_timeout", 40);
    check("burst3_words_done", {27'd0, words_done}, 32'd3);
    check("burst3_strobes", strobes - s0, 32'd3);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);

    // Empty FIFO for 10 cycles, then one word arrives.
    s0 = strobes;
    start_burst(1);
    repeat (10) tick();
    check("empty_no_strobe", strobes - s0, 32'd0);
    check("empty_busy", {31'd0, busy}, 32'd1);
    push(8'hA5);
    exp_q.push_back(8'hA5);
    wait_done("empty_done_timeout", 40);
    check("empty_strobes", strobes - s0, 32'd1);
    check("empty_words_done", {27'd0, words_done}, 32'd1);
    tick();

    // Back-pressure: word held stable, no second read until accept.
    bus.m_ready = 1'b0;
    push(8'h5A); push(8'h5B);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    s0 = strobes;
    start_burst(2);
    wait_valid("bp_valid_timeout", 20);
    repeat (5) tick();
    check("bp_m_data", {24'd0, bus.m_data}, 32'h5A);
    check("bp_strobes", strobes - s0, 32'd1);
    bus.m_ready = 1'b1;
    wait_done("bp_done_timeout", 40);
    check("bp_words_done", {27'd0, words_done}, 32'd2);
    tick();

    // Abort during WAIT of word 2 of a 4-word burst.
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    s0 = strobes;
    start_burst(4);
    begin
      int n;
      int seen;
      n = 0;
      seen = 0;
      while (seen < 2 && n < 40) begin
        if (bus.fifo_rd_en) seen++;
        if (seen < 2) tick();
        n++;
      end
      if (seen < 2) check("abort_strobe_timeout", seen, 32'd2);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort_done_timeout", 40);
    check("abort_words_done", {27'd0, words_done}, 32'd2);
    check("abort_fifo_left", wp - rp, 32'd2);
    tick();
    check("abort_strobes", strobes - s0, 32'd2);
    rp = wp;  // flush leftovers from the model

    // Reset while holding a word, then a zero-length start.
    bus.m_ready = 1'b0;
    push(8'h77);
    start_burst(1);
    wait_valid("rsthold_valid_timeout", 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsthold_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rsthold_m_data", {24'd0, bus.m_data}, 32'd0);
    check("rsthold_busy", {31'd0, busy}, 32'd0);
    check("rsthold_words_done", {27'd0, words_done}, 32'd0);
    s0 = strobes;
    start_burst(0);
    repeat (3) tick();
    check("rsthold_busy_after", {31'd0, busy}, 32'd0);
    check("rsthold_no_strobe", strobes - s0, 32'd0);
    bus.m_ready = 1'b1;

`ifdef FIFO_DRAIN_TIMEOUT_EN
    // Empty FIFO: burst abandoned after TIMEOUT stall cycles.
    cyc0 = cyc;
    start_burst(2);
    wait_done("timeout_done_timeout", 40);
    check("timeout_latency", cyc - cyc0, 32'd10);
    check("timeout_flag", {31'd0, timed_out}, 32'd1);
    check("timeout_words_done", {27'd0, words_done}, 32'd0);
    tick();
    check("timeout_sticky", {31'd0, timed_out}, 32'd1);
`else
    cyc0 = 0;
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d, expected finish earlier", cyc);
    $fatal(1, "time limit");
  end
endmodule
